// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencer for the HI/LO multiply/divide unit. Accepts one command at a time,
//   hands the operands to an external multiplier or divider over an
//   alternating-bit (ABP) handshake, and writes the results back into the
//   architectural HI/LO registers.
//
//   Optional feature: define MULDIV_MADD_EN to enable op 111 (MADD,
//   {HI,LO} += signed a*b). Without it op 111 is a NOP and no
//   accumulate adder exists.
//
// Ports
//   sys_clock_i, sys_reset_i      clock (rising edge), async active-high reset
//   cmd_valid_i, cmd_op_i, a_i, b_i, cmd_ready_o   command interface
//   hi_o, lo_o, dz_o              HI/LO registers, sticky divide-by-zero flag
//   mul_a_o, mul_b_o, mul_signed_o, mul_req_o, mul_ack_i, mul_product_i
//                                 multiplier ABP interface
//   div_a_o, div_b_o, div_signed_o, div_req_o, div_ack_i,
//   div_quotient_i, div_remainder_i
//                                 divider ABP interface
// -----------------------------------------------------------------------------
module muldiv_ctrl (
    input  logic        sys_clock_i,
    input  logic        sys_reset_i,
    input  logic        cmd_valid_i,
    input  logic [2:0]  cmd_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        cmd_ready_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        dz_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_signed_o,
    output logic        mul_req_o,
    input  logic        mul_ack_i,
    input  logic [63:0] mul_product_i,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_signed_o,
    output logic        div_req_o,
    input  logic        div_ack_i,
    input  logic [31:0] div_quotient_i,
    input  logic [31:0] div_remainder_i
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        ACC      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        dz_q, dz_d;
    logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic        mul_signed_q, mul_signed_d, mul_req_q, mul_req_d;
    logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d;
    logic        div_signed_q, div_signed_d, div_req_q, div_req_d;
`ifdef MULDIV_MADD_EN
    // Remembers that the outstanding multiply is a MADD, so MUL_WAIT
    // diverts to ACC instead of overwriting HI/LO.
    logic        madd_q, madd_d;
`endif

    // ABP: a unit is finished once its ack level has caught up with our req.
    logic mul_done, div_done;
    assign mul_done = (mul_ack_i == mul_req_q);
    assign div_done = (div_ack_i == div_req_q);

    // State register
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        OP_MULT, OP_MULTU: state_d = MUL_WAIT;
`ifdef MULDIV_MADD_EN
                        OP_MADD:           state_d = MUL_WAIT;
`else
                        OP_MADD:           state_d = IDLE;
`endif
                        OP_DIV, OP_DIVU:   if (b_i != 32'd0) state_d = DIV_WAIT;
                        default:           state_d = IDLE;
                    endcase
                end
            end
            MUL_WAIT: begin
                if (mul_done) begin
`ifdef MULDIV_MADD_EN
                    state_d = madd_q ? ACC : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            DIV_WAIT: if (div_done) state_d = IDLE;
            ACC:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        cmd_ready_o  = (state_q == IDLE);
        hi_d         = hi_q;
        lo_d         = lo_q;
        dz_d         = dz_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        mul_req_d    = mul_req_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_signed_d = div_signed_q;
        div_req_d    = div_req_q;
`ifdef MULDIV_MADD_EN
        madd_d       = madd_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd_op_i)
                        OP_MULT, OP_MULTU: begin
                            mul_a_d      = a_i;
                            mul_b_d      = b_i;
                            mul_signed_d = (cmd_op_i == OP_MULT);
                            mul_req_d    = ~mul_req_q;
`ifdef MULDIV_MADD_EN
                            madd_d       = 1'b0;
`endif
                        end
`ifdef MULDIV_MADD_EN
                        OP_MADD: begin
                            mul_a_d      = a_i;
                            mul_b_d      = b_i;
                            mul_signed_d = 1'b1;
                            mul_req_d    = ~mul_req_q;
                            madd_d       = 1'b1;
                        end
`else
                        OP_MADD: ;
`endif
                        OP_DIV, OP_DIVU: begin
                            // Zero divisor never reaches the divider.
                            if (b_i == 32'd0) begin
                                dz_d = 1'b1;
                            end else begin
                                div_a_d      = a_i;
                                div_b_d      = b_i;
                                div_signed_d = (cmd_op_i == OP_DIV);
                                div_req_d    = ~div_req_q;
                            end
                        end
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
`ifdef MULDIV_MADD_EN
                if (mul_done && !madd_q) {hi_d, lo_d} = mul_product_i;
`else
                if (mul_done) {hi_d, lo_d} = mul_product_i;
`endif
            end
            DIV_WAIT: begin
                if (div_done) begin
                    lo_d = div_quotient_i;
                    hi_d = div_remainder_i;
                end
            end
            ACC: begin
`ifdef MULDIV_MADD_EN
                // Product is still held by the multiplier after its ack.
                {hi_d, lo_d} = {hi_q, lo_q} + mul_product_i;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            hi_q         <= '0;
            lo_q         <= '0;
            dz_q         <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            mul_req_q    <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_signed_q <= 1'b0;
            div_req_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            madd_q       <= 1'b0;
`endif
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dz_q         <= dz_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            mul_req_q    <= mul_req_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_signed_q <= div_signed_d;
            div_req_q    <= div_req_d;
`ifdef MULDIV_MADD_EN
            madd_q       <= madd_d;
`endif
        end
    end

    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign dz_o         = dz_q;
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign mul_signed_o = mul_signed_q;
    assign mul_req_o    = mul_req_q;
    assign div_a_o      = div_a_q;
    assign div_b_o      = div_b_q;
    assign div_signed_o = div_signed_q;
    assign div_req_o    = div_req_q;

endmodule
